arbitro_memoria: RTL and testbench

Two-requester arbiter and access sequencer for the shared data memory (`memoria_compartilhada`, 512 × 32-bit words). It sits between two bus masters (port 0 and port 1, e.g. CPU core and a second core/DMA) and the single memory port. It grants one access at a time, drives the memory's address, data and strobe lines for exactly one cycle, and returns read data with a one-cycle acknowledge. It also rejects out-of-range addresses without touching memory.

---
 rtl/arbitro_memoria.sv | 141 ++++++++++++++
 tb/tb_arbitro_memoria.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
// Two-port arbiter and single-cycle access sequencer for the shared data memory.
// Optional build macro ARB_PRIORIDADE_FIXA_EN selects fixed priority (port 0 wins ties).
module arbitro_memoria #(
  parameter int unsigned LARGURA      = 32,
  parameter int unsigned PROFUNDIDADE = 512
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [LARGURA-1:0] addr0,
  input  logic [LARGURA-1:0] addr1,
  input  logic [LARGURA-1:0] wdata0,
  input  logic [LARGURA-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic [LARGURA-1:0] rdata0,
  output logic [LARGURA-1:0] rdata1,
  output logic               erro0,
  output logic               erro1,
  output logic [LARGURA-1:0] mem_endereco,
  output logic [LARGURA-1:0] mem_indata,
  output logic               mem_lerMem,
  output logic               mem_escMem,
  input  logic [LARGURA-1:0] mem_output
);

  typedef enum logic [1:0] {
    Ocioso,
    Acesso,
    Retorno
  } estado_t;

  estado_t            estado;
  logic               dono;
  logic               we_lat;
  logic               vencedor;
  logic               sel_we;
  logic [LARGURA-1:0] sel_addr;
  logic [LARGURA-1:0] sel_wdata;

`ifdef ARB_PRIORIDADE_FIXA_EN
  always_comb begin
    vencedor = ~req0;
  end
`else
  logic ultimo;

  // On a tie the port that was not served last wins; otherwise the lone requester.
  always_comb begin
    if (req0 && req1) begin
      vencedor = ~ultimo;
    end else begin
      vencedor = ~req0;
    end
  end
`endif

  always_comb begin
    sel_we    = vencedor ? we1    : we0;
    sel_addr  = vencedor ? addr1  : addr0;
    sel_wdata = vencedor ? wdata1 : wdata0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= Ocioso;
      dono         <= 1'b0;
      we_lat       <= 1'b0;
`ifndef ARB_PRIORIDADE_FIXA_EN
      ultimo       <= 1'b1;
`endif
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      erro0        <= 1'b0;
      erro1        <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      mem_endereco <= '0;
      mem_indata   <= '0;
      mem_lerMem   <= 1'b0;
      mem_escMem   <= 1'b0;
    end else begin
      unique case (estado)
        Ocioso: begin
          if (req0 || req1) begin
            dono   <= vencedor;
            we_lat <= sel_we;
`ifndef ARB_PRIORIDADE_FIXA_EN
            ultimo <= vencedor;
`endif
            if (sel_addr < LARGURA'(PROFUNDIDADE)) begin
              mem_endereco <= sel_addr;
              mem_indata   <= sel_wdata;
              mem_lerMem   <= ~sel_we;
              mem_escMem   <= sel_we;
              estado       <= Acesso;
            end else begin
              // Out-of-range: answer straight away with an error, memory untouched.
              if (vencedor) begin
                ack1  <= 1'b1;
                erro1 <= 1'b1;
                if (!sel_we) rdata1 <= '0;
              end else begin
                ack0  <= 1'b1;
                erro0 <= 1'b1;
                if (!sel_we) rdata0 <= '0;
              end
              estado <= Retorno;
            end
          end
        end
        Acesso: begin
          mem_lerMem <= 1'b0;
          mem_escMem <= 1'b0;
          if (dono) begin
            ack1 <= 1'b1;
            if (!we_lat) rdata1 <= mem_output;
          end else begin
            ack0 <= 1'b1;
            if (!we_lat) rdata0 <= mem_output;
          end
          estado <= Retorno;
        end
        Retorno: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          erro0  <= 1'b0;
          erro1  <= 1'b0;
          estado <= Ocioso;
        end
        default: begin
          estado <= Ocioso;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria with a behavioural 512-word memory.
module tb_arbitro_memoria;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, erro0, erro1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_endereco, mem_indata, mem_output;
  logic        mem_lerMem, mem_escMem;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [512];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_escMem) mem[mem_endereco[8:0]] <= mem_indata;
  end
  assign mem_output = mem[mem_endereco[8:0]];

  arbitro_memoria #(
    .LARGURA     (32),
    .PROFUNDIDADE(512)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .erro0       (erro0),
    .erro1       (erro1),
    .mem_endereco(mem_endereco),
    .mem_indata  (mem_indata),
    .mem_lerMem  (mem_lerMem),
    .mem_escMem  (mem_escMem),
    .mem_output  (mem_output)
  );

  typedef struct {
    bit          porta;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_erro;
    int          exp_edge;   // edge index (1 = sampling edge) after which ack is first seen
    int          exp_esc;
    int          exp_ler;
  } vec_t;

  vec_t tab[9];

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask

  task automatic transacao(input vec_t v, input string nome);
    int          edge_ack = 0;
    int          nesc = 0;
    int          nler = 0;
    int          outro = 0;
    logic [31:0] end_visto = '0;
    logic [31:0] rd = '0;
    logic        er = 1'b0;
    if (v.porta) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    for (int c = 1; c <= 8; c++) begin
      ciclo();
      if (mem_escMem) begin nesc++; end_visto = mem_endereco; end
      if (mem_lerMem) begin nler++; end_visto = mem_endereco; end
      if (v.porta ? ack0 : ack1) outro++;
      if (v.porta ? ack1 : ack0) begin
        edge_ack = c;
        er = v.porta ? erro1 : erro0;
        rd = v.porta ? rdata1 : rdata0;
        break;
      end
    end
    ciclo();
    req0 = 1'b0;
    req1 = 1'b0;
    if (edge_ack == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s_timeout: got no ack expected ack", nome);
    end else begin
      chk({nome, "_lat"}, edge_ack, v.exp_edge);
      chk({nome, "_erro"}, er, v.exp_erro);
      chk({nome, "_esc"}, nesc, v.exp_esc);
      chk({nome, "_ler"}, nler, v.exp_ler);
      chk({nome, "_outro_ack"}, outro, 0);
      if (v.exp_esc + v.exp_ler > 0) chk({nome, "_end"}, end_visto, v.addr);
      if (!v.we) chk({nome, "_rdata"}, rd, v.exp_rdata);
    end
  endtask

  initial begin
    int portas[8];
    int tempos[8];
    int n;
    int ambos;
    int n_ack1;
    int acks;
    vec_t vr;

    for (int i = 0; i < 512; i++) mem[i] = '0;
    //       porta we addr         wdata         exp_rdata     erro edge esc ler
    tab[0] = '{1'b0, 1'b1, 32'd5,        32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 0};
    tab[1] = '{1'b1, 1'b0, 32'd5,        32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1};
    tab[2] = '{1'b1, 1'b1, 32'd511,      32'h12345678, 32'h0,        1'b0, 2, 1, 0};
    tab[3] = '{1'b0, 1'b0, 32'd511,      32'h0,        32'h12345678, 1'b0, 2, 0, 1};
    tab[4] = '{1'b0, 1'b1, 32'd512,      32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0};
    tab[5] = '{1'b0, 1'b0, 32'd0,        32'h0,        32'h0,        1'b0, 2, 0, 1};
    tab[6] = '{1'b1, 1'b1, 32'd0,        32'hA5A5A5A5, 32'h0,        1'b0, 2, 1, 0};
    tab[7] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    tab[8] = '{1'b0, 1'b0, 32'd0,        32'h0,        32'hA5A5A5A5, 1'b0, 2, 0, 1};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) ciclo();
    reset = 1'b0;
    ciclo();
    chk("rst_acks", {ack1, ack0}, 2'b00);
    chk("rst_erros", {erro1, erro0}, 2'b00);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_strobes", {mem_lerMem, mem_escMem}, 2'b00);
    chk("rst_endereco", mem_endereco, 32'h0);
    chk("rst_indata", mem_indata, 32'h0);

    for (int i = 0; i < 9; i++) begin
      transacao(tab[i], $sformatf("v%0d", i));
      if (i == 2) chk("hold_rdata1_after_write", rdata1, 32'hDEADBEEF);
    end
    repeat (3) ciclo();
    chk("hold_rdata0", rdata0, 32'hA5A5A5A5);
    chk("hold_rdata1_invalid", rdata1, 32'h0);

    // Continuous contention from reset.
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd511;
    n = 0; ambos = 0; n_ack1 = 0;
    for (int k = 0; k < 8; k++) begin portas[k] = 0; tempos[k] = 0; end
    for (int c = 1; c <= 14; c++) begin
      ciclo();
      if (ack0 && ack1) ambos++;
      if (ack1) n_ack1++;
      if (ack0 || ack1) begin
        if (n < 8) begin portas[n] = int'(ack1); tempos[n] = c; end
        n++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) ciclo();
    chk("cont_n_ge4", 32'(n >= 4), 32'd1);
    chk("cont_ambos", ambos, 0);
    chk("cont_first_edge", tempos[0], 2);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_PRIORIDADE_FIXA_EN
      chk($sformatf("cont_porta%0d", k), portas[k], 0);
`else
      chk($sformatf("cont_porta%0d", k), portas[k], k % 2);
`endif
      if (k > 0) chk($sformatf("cont_gap%0d", k), tempos[k] - tempos[k-1], 3);
    end
`ifdef ARB_PRIORIDADE_FIXA_EN
    chk("cont_ack1_pulses", n_ack1, 0);
`else
    chk("cont_ack1_pulses", 32'(n_ack1 >= 2), 32'd1);
`endif

    // Reset during the access cycle of a read.
    transacao(tab[8], "pre_abort");
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    ciclo();
    chk("abort_lerMem_high", mem_lerMem, 1'b1);
    reset = 1'b1;
    req0 = 1'b0;
    ciclo();
    chk("abort_strobes", {mem_lerMem, mem_escMem}, 2'b00);
    chk("abort_ack0", ack0, 1'b0);
    chk("abort_rdata0", rdata0, 32'h0);
    reset = 1'b0;
    acks = 0;
    repeat (4) begin
      ciclo();
      if (ack0 || ack1) acks++;
    end
    chk("abort_no_ack", acks, 0);
    vr = '{1'b0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1};
    transacao(vr, "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
